// File: rtl/vds_scaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vds_scaler : active-area scanner issuing power-of-two replicated          |
// | framebuffer addresses with registered, sync-aligned RGB return path.      |
// | Optional border overlay: define VDS_BORDER_EN.          Revision: 1.0     |
// +--------------------------------------------------------------------------+
module vds_scaler #(
  parameter int H_ACT      = 800,
  parameter int V_ACT      = 600,
  parameter int ADDR_W     = 15,
  parameter int RGB_W      = 12,
  parameter int RD_LAT     = 1,
  parameter int MIN_SHIFT  = 2,
  parameter int BLANK_ADDR = 7500
`ifdef VDS_BORDER_EN
  , parameter logic [RGB_W-1:0] BORDER_RGB = {RGB_W{1'b1}}
`endif
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              hen,
  input  logic              ven,
  input  logic [1:0]        scale_sel,
  input  logic [RGB_W-1:0]  rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic [RGB_W-1:0]  prgb,
  output logic              hen_o,
  output logic              ven_o,
  output logic              frame_done
);

  localparam int XP_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YP_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam logic [XP_W-1:0]   XP_LAST  = XP_W'(H_ACT - 1);
  localparam logic [YP_W-1:0]   YP_LAST  = YP_W'(V_ACT - 1);
  localparam logic [1:0]        MIN_SH   = 2'(MIN_SHIFT);
  localparam logic [ADDR_W-1:0] BLANK    = ADDR_W'(BLANK_ADDR);
  localparam int                MAX_ADDR = (V_ACT >> MIN_SHIFT) * (H_ACT >> MIN_SHIFT) - 1;

  if (MAX_ADDR >= (1 << ADDR_W)) begin : g_addr_check
    $error("vds_scaler: framebuffer at MIN_SHIFT does not fit ADDR_W");
  end

  logic [2:0]        xs_q, xs_d, ys_q, ys_d;
  logic [ADDR_W-1:0] xf_q, xf_d, row_base_q, row_base_d;
  logic [XP_W-1:0]   xp_q, xp_d;
  logic [YP_W-1:0]   yp_q, yp_d;
  logic [1:0]        shift_q, shift_d;
  logic              arm_q, arm_d;
  logic              ven_q;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              frame_done_q, frame_done_d;

  logic              w_de;
  logic [1:0]        w_sh, w_shift;
  logic [2:0]        w_sub_max;
  logic [ADDR_W-1:0] w_stride;

  assign w_de      = hen & ven;
  assign w_sh      = (scale_sel < MIN_SH) ? MIN_SH : scale_sel;
  // While armed (frame start) the request is live, so the first pixel already scales correctly.
  assign w_shift   = arm_q ? w_sh : shift_q;
  assign w_sub_max = 3'((4'd1 << w_shift) - 4'd1);
  assign w_stride  = ADDR_W'(H_ACT >> w_shift);

  always_comb begin
    xs_d         = xs_q;
    ys_d         = ys_q;
    xf_d         = xf_q;
    xp_d         = xp_q;
    yp_d         = yp_q;
    row_base_d   = row_base_q;
    shift_d      = arm_q ? w_sh : shift_q;
    arm_d        = arm_q;
    raddr_d      = BLANK;
    frame_done_d = 1'b0;
    if (w_de) begin
      raddr_d = row_base_q + xf_q;
      arm_d   = 1'b0;
      if (xp_q == XP_LAST) begin
        xs_d = '0;
        xf_d = '0;
        xp_d = '0;
        if (yp_q == YP_LAST) begin
          frame_done_d = 1'b1;
          ys_d         = '0;
          yp_d         = '0;
          row_base_d   = '0;
          arm_d        = 1'b1;
        end else begin
          yp_d = yp_q + YP_W'(1);
          if (ys_q == w_sub_max) begin
            ys_d       = '0;
            row_base_d = row_base_q + w_stride;
          end else begin
            ys_d = ys_q + 3'd1;
          end
        end
      end else begin
        xp_d = xp_q + XP_W'(1);
        if (xs_q == w_sub_max) begin
          xs_d = '0;
          xf_d = xf_q + ADDR_W'(1);
        end else begin
          xs_d = xs_q + 3'd1;
        end
      end
    end else if (ven_q && !ven && (xp_q != '0 || yp_q != '0)) begin
      // ven fell before the frame completed: treat as a short frame.
      xs_d       = '0;
      ys_d       = '0;
      xf_d       = '0;
      xp_d       = '0;
      yp_d       = '0;
      row_base_d = '0;
      arm_d      = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      xs_q         <= '0;
      ys_q         <= '0;
      xf_q         <= '0;
      xp_q         <= '0;
      yp_q         <= '0;
      row_base_q   <= '0;
      shift_q      <= MIN_SH;
      arm_q        <= 1'b1;
      ven_q        <= 1'b0;
      raddr_q      <= BLANK;
      frame_done_q <= 1'b0;
    end else begin
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      xf_q         <= xf_d;
      xp_q         <= xp_d;
      yp_q         <= yp_d;
      row_base_q   <= row_base_d;
      shift_q      <= shift_d;
      arm_q        <= arm_d;
      ven_q        <= ven;
      raddr_q      <= raddr_d;
      frame_done_q <= frame_done_d;
    end
  end

  logic [RD_LAT:0]   de_pipe_q, de_pipe_d, hen_pipe_q, hen_pipe_d, ven_pipe_q, ven_pipe_d;
  logic [RGB_W-1:0]  prgb_q, prgb_d;

`ifdef VDS_BORDER_EN
  logic [RD_LAT:0] bd_pipe_q, bd_pipe_d;
  logic            w_border;

  assign w_border = w_de & ((xp_q == '0) | (xp_q == XP_LAST) | (yp_q == '0) | (yp_q == YP_LAST));

  always_comb begin
    bd_pipe_d = {bd_pipe_q[RD_LAT-1:0], w_border};
    prgb_d    = '0;
    if (de_pipe_q[RD_LAT]) begin
      prgb_d = bd_pipe_q[RD_LAT] ? BORDER_RGB : rdata;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      bd_pipe_q <= '0;
    end else begin
      bd_pipe_q <= bd_pipe_d;
    end
  end
`else
  always_comb begin
    prgb_d = de_pipe_q[RD_LAT] ? rdata : '0;
  end
`endif

  always_comb begin
    de_pipe_d  = {de_pipe_q[RD_LAT-1:0], w_de};
    hen_pipe_d = {hen_pipe_q[RD_LAT-1:0], hen};
    ven_pipe_d = {ven_pipe_q[RD_LAT-1:0], ven};
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      de_pipe_q  <= '0;
      hen_pipe_q <= '0;
      ven_pipe_q <= '0;
      prgb_q     <= '0;
    end else begin
      de_pipe_q  <= de_pipe_d;
      hen_pipe_q <= hen_pipe_d;
      ven_pipe_q <= ven_pipe_d;
      prgb_q     <= prgb_d;
    end
  end

  assign raddr      = raddr_q;
  assign frame_done = frame_done_q;
  assign prgb       = prgb_q;
  assign hen_o      = hen_pipe_q[RD_LAT];
  assign ven_o      = ven_pipe_q[RD_LAT];

endmodule
`default_nettype wire

// File: tb/tb_vds_scaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vds_scaler : randomized frames against a position-based address model. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vds_scaler;
  localparam int H  = 64;
  localparam int V  = 48;
  localparam int AW = 9;
  localparam int RW = 12;
  localparam int RL = 2;
  localparam int MS = 2;
  localparam int BA = 300;

  logic          pclk = 1'b0;
  logic          rst  = 1'b1;
  logic          hen  = 1'b0;
  logic          ven  = 1'b0;
  logic [1:0]    scale_sel = 2'd0;
  logic [RW-1:0] rdata = '0;
  logic [AW-1:0] raddr;
  logic [RW-1:0] prgb;
  logic          hen_o, ven_o, frame_done;

  vds_scaler #(
    .H_ACT(H), .V_ACT(V), .ADDR_W(AW), .RGB_W(RW),
    .RD_LAT(RL), .MIN_SHIFT(MS), .BLANK_ADDR(BA)
  ) dut (
    .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .scale_sel(scale_sel),
    .rdata(rdata), .raddr(raddr), .prgb(prgb), .hen_o(hen_o), .ven_o(ven_o),
    .frame_done(frame_done)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // model state: position inside the frame, counted in de cycles
  int mx, my, msh;
  bit started, ven_prev;

  int exp_raddr[16];
  int fsh_h[16];
  bit exp_fd[16], de_h[16], hen_h[16], ven_h[16], bord_h[16];
  int ra_obs[16];

  function automatic int addr_of(input int x, input int y, input int sh);
    return (y >> sh) * (H >> sh) + (x >> sh);
  endfunction

  function automatic int pat(input int a);
    return (a * 37 + 11) & 12'hFFF;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d iter=%0d", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; msh = MS; started = 0; ven_prev = 0;
    for (int i = 0; i < 16; i++) begin
      exp_raddr[i] = BA; exp_fd[i] = 0; de_h[i] = 0; hen_h[i] = 0;
      ven_h[i] = 0; bord_h[i] = 0; fsh_h[i] = MS; ra_obs[i] = BA;
    end
  endtask

  task automatic check_outputs();
    int k, exp_p;
    k = (n - 1) & 15;
    chk("raddr", int'(raddr), exp_raddr[k]);
    chk("frame_done", int'(frame_done), int'(exp_fd[k]));
    if (frame_done)
      chk("last_addr", int'(raddr), (fsh_h[k] == 3) ? 47 : 191);
    k = (n - RL - 1) & 15;
    chk("hen_o", int'(hen_o), int'(hen_h[k]));
    chk("ven_o", int'(ven_o), int'(ven_h[k]));
    k = (n - RL - 2) & 15;
    exp_p = 0;
    if (de_h[k]) begin
      exp_p = pat(exp_raddr[k]);
`ifdef VDS_BORDER_EN
      if (bord_h[k]) exp_p = 12'hFFF;
`endif
    end
    chk("prgb", int'(prgb), exp_p);
  endtask

  task automatic step(input bit h, input bit v);
    int k;
    bit de;
    @(negedge pclk);
    check_outputs();
    ra_obs[n & 15] = int'(raddr);
    rdata = RW'(pat(ra_obs[(n - RL) & 15]));
    hen = h;
    ven = v;
    de = h & v;
    k = n & 15;
    de_h[k] = de; hen_h[k] = h; ven_h[k] = v;
    exp_fd[k] = 0; bord_h[k] = 0; exp_raddr[k] = BA; fsh_h[k] = msh;
    if (de) begin
      if (!started) begin
        msh = (int'(scale_sel) < MS) ? MS : int'(scale_sel);
        started = 1;
      end
      fsh_h[k] = msh;
      exp_raddr[k] = addr_of(mx, my, msh);
      bord_h[k] = (mx == 0 || mx == H - 1 || my == 0 || my == V - 1);
      if (mx == H - 1 && my == V - 1) begin
        exp_fd[k] = 1; mx = 0; my = 0; started = 0;
      end else if (mx == H - 1) begin
        mx = 0; my++;
      end else begin
        mx++;
      end
    end else if (ven_prev && !v && (mx != 0 || my != 0)) begin
      mx = 0; my = 0; started = 0;
    end
    ven_prev = v;
    n++;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_raddr", int'(raddr), BA);
    chk("rst_prgb", int'(prgb), 0);
    chk("rst_hen_o", int'(hen_o), 0);
    chk("rst_ven_o", int'(ven_o), 0);
    chk("rst_fd", int'(frame_done), 0);
    hen = 1'b0; ven = 1'b0; rdata = '0;
    model_reset();
    @(posedge pclk);
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
  endtask

  // lines: active lines to emit (< V gives a short frame); chg_line: line at which scale_sel changes
  task automatic run_frame(input int lines, input bit gaps, input int chg_line, input int new_ss,
                           input int rst_line);
    int px;
    for (int y = 0; y < lines; y++) begin
      if (y == chg_line) scale_sel = 2'(new_ss);
      px = 0;
      while (px < H) begin
        if (y == rst_line && px == H / 2) begin
          do_reset();
          return;
        end
        if (gaps && $urandom_range(0, 15) == 0) begin
          step(1'b0, 1'b1);
        end else begin
          step(1'b1, 1'b1);
          px++;
        end
      end
      for (int b = 0; b < int'($urandom_range(3, 8)); b++) step(1'b0, 1'b1);
    end
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < H; b++) step(1'b1, 1'b0);
      for (int b = 0; b < 6; b++) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("pin_8x_col8", addr_of(8, 0, 3), 1);
    chk("pin_8x_line8", addr_of(0, 8, 3), 8);
    chk("pin_8x_last", addr_of(H - 1, V - 1, 3), 47);
    chk("pin_4x_px4", addr_of(4, 0, 2), 1);
    chk("pin_4x_last", addr_of(H - 1, V - 1, 2), 191);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    scale_sel = 2'd3;
    run_frame(V, 1'b0, V / 2, 2, -1);       // stays 8x after mid-frame request
    run_frame(V, 1'b0, -1, 0, -1);          // 4x from the request
    scale_sel = 2'd0;
    run_frame(V, 1'b1, -1, 0, -1);          // clamped to MIN_SHIFT
    scale_sel = 2'd3;
    run_frame(20, 1'b0, -1, 0, -1);         // short frame, resync
    run_frame(V, 1'b1, -1, 0, -1);
    scale_sel = 2'd1;
    run_frame(V, 1'b0, 10, 3, 15);          // async reset mid-line
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      scale_sel = 2'($urandom_range(0, 3));
      run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, V - 1)) : V, 1'b1,
                int'($urandom_range(1, V - 1)), int'($urandom_range(0, 3)), -1);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
